// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRA/SRL/ROR). Latency is PIPE_STAGES cycles.
// A single global stall freezes every rank while the result waits for out_ready.
module pipelined_shifter #(
  parameter int WIDTH       = 16,
  parameter int PIPE_STAGES = 2,
  localparam int SHW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRA = 2'b01;
  localparam logic [1:0] MODE_SRL = 2'b10;

  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                   input logic [1:0] mode,
                                                   input logic sgn,
                                                   input int sh);
    logic [2*WIDTH-1:0] ext;
    case (mode)
      MODE_SLL: ext = {{WIDTH{1'b0}}, d} << sh;
      MODE_SRA: ext = {{WIDTH{sgn}}, d} >> sh;
      MODE_SRL: ext = {{WIDTH{1'b0}}, d} >> sh;
      default:  ext = {d, d} >> sh;
    endcase
    return ext[WIDTH-1:0];
  endfunction

  logic stall;

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_rank
    // Levels LO..HI are evaluated combinationally ahead of this rank's registers.
    localparam int LO = s * SHW / PIPE_STAGES;
    localparam int HI = ((s + 1) * SHW / PIPE_STAGES) - 1;

    logic [WIDTH-1:0] src_dat;
    logic [SHW-1:LO]  src_amt;
    logic [1:0]       src_mode;
    logic             src_sgn;
    logic             src_vld;
    logic [WIDTH-1:0] dat_d;
    logic [WIDTH-1:0] dat_q;
    logic             vld_q;

    if (s == 0) begin : g_src
      assign src_dat  = in_data;
      assign src_amt  = in_amt;
      assign src_mode = in_mode;
      assign src_sgn  = in_data[WIDTH-1];
      assign src_vld  = in_valid;
    end else begin : g_src
      assign src_dat  = g_rank[s-1].dat_q;
      assign src_amt  = g_rank[s-1].g_ctl.amt_q;
      assign src_mode = g_rank[s-1].g_ctl.mode_q;
      assign src_sgn  = g_rank[s-1].g_ctl.sgn_q;
      assign src_vld  = g_rank[s-1].vld_q;
    end

    always_comb begin
      dat_d = src_dat;
      for (int k = LO; k <= HI; k++) begin
        if (src_amt[k]) dat_d = shift_level(dat_d, src_mode, src_sgn, 1 << k);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
      end else if (!stall) begin
        vld_q <= src_vld;
      end
    end

    always_ff @(posedge clk) begin
      if (!stall) dat_q <= dat_d;
    end

    // Only ranks that still have levels downstream carry the control fields.
    if (s < PIPE_STAGES - 1) begin : g_ctl
      logic [SHW-1:HI+1] amt_q;
      logic [1:0]        mode_q;
      logic              sgn_q;

      always_ff @(posedge clk) begin
        if (!stall) begin
          amt_q  <= src_amt[SHW-1:HI+1];
          mode_q <= src_mode;
          sgn_q  <= src_sgn;
        end
      end
    end
  end

  assign out_valid = g_rank[PIPE_STAGES-1].vld_q;
  assign out_data  = out_valid ? g_rank[PIPE_STAGES-1].dat_q : '0;
  assign out_zero  = out_valid && (out_data == '0);
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter (WIDTH=16, PIPE_STAGES=2).
module tb_pipelined_shifter;
  localparam int W = 16;
  localparam int P = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [3:0]    in_amt;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_zero;

  pipelined_shifter #(.WIDTH(W), .PIPE_STAGES(P)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [W-1:0] dat;
    logic         zero;
    int           acc;
    bit           lat;
  } exp_t;
  exp_t sbq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [3:0] a,
                                         input logic [1:0] m);
    logic signed [W-1:0] sd;
    sd = d;
    case (m)
      2'd0:    return d << a;
      2'd1:    return sd >>> a;
      2'd2:    return d >> a;
      default: return (a == 0) ? d : ((d >> a) | (d << (W - a)));
    endcase
  endfunction

  // Monitor: pops the scoreboard on every handshake, and checks stall behaviour.
  bit           stall_prev = 1'b0;
  logic [W-1:0] held;
  exp_t         mon_e;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_hold_vld", out_valid, 1);
        check("stall_hold_dat", out_data, held);
      end
      if (out_valid && !out_ready) begin
        check("stall_in_ready", in_ready, 0);
        stall_prev = 1'b1;
        held       = out_data;
      end else begin
        stall_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_out_vld", out_valid, 0);
        end else begin
          mon_e = sbq.pop_front();
          check("out_data", out_data, mon_e.dat);
          check("out_zero", out_zero, mon_e.zero);
          if (mon_e.lat) check("latency", cyc - mon_e.acc + 1, P);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input logic [W-1:0] d, input logic [3:0] a, input logic [1:0] m,
                      input logic [W-1:0] exp, input bit lat);
    int   waited;
    exp_t e;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_mode  = m;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 50) begin
        check("send_timeout", in_ready, 1);
        in_valid = 1'b0;
        return;
      end
    end
    e.dat  = exp;
    e.zero = (exp == '0);
    e.acc  = cyc + 1;
    e.lat  = lat;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    in_valid = 1'b0;
    t = 0;
    while (sbq.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (sbq.size() != 0) check("drain", sbq.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] d;
    logic [3:0]   a;
    logic [1:0]   m;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_zero", out_zero, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b0;

    // Modes, zero flag and identity (amt 0 in every mode)
    send(16'h8001, 4'd4,  2'd0, 16'h0010, 1);
    send(16'h8000, 4'd15, 2'd1, 16'hFFFF, 1);
    send(16'h8000, 4'd15, 2'd2, 16'h0001, 1);
    send(16'h1234, 4'd4,  2'd3, 16'h4123, 1);
    send(16'h8000, 4'd1,  2'd0, 16'h0000, 1);
    send(16'h7FF0, 4'd3,  2'd1, 16'h0FFE, 1);
    send(16'h000F, 4'd2,  2'd3, 16'hC003, 1);
    for (int i = 0; i < 4; i++) send(16'hA5A5, 4'd0, 2'(i), 16'hA5A5, 1);
    drain();

    // Streaming: back-to-back with a fixed latency implies gap-free output
    for (int i = 0; i < 16; i++) begin
      d = 16'($urandom);
      a = 4'($urandom_range(0, 15));
      m = 2'($urandom_range(0, 3));
      send(d, a, m, model(d, a, m), 1);
    end
    drain();

    // Backpressure: consumer stalls for 3 cycles with the pipe full
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          d = 16'h1000 + 16'(i * 16'h0111);
          a = 4'(i);
          m = 2'(i % 4);
          send(d, a, m, model(d, a, m), 0);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(16'h1111, 4'd1, 2'd0, 16'h2222, 0);
    send(16'h2222, 4'd1, 2'd2, 16'h1111, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    sbq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_zero", out_zero, 0);
    check("midrst_in_ready", in_ready, 1);
    repeat (5) begin
      @(negedge clk);
      check("no_stale", out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(16'h00F0, 4'd3, 2'd2, 16'h001E, 1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
